// File: rtl/fir_uart_pkg.sv
// Shared types and helpers for the FIR-to-UART result path.
package fir_uart_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} tx_sched_state_t;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned nbytes(input int unsigned width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/fir_tx_scheduler_if.sv
// Bundle of FIR-side, UART-side and status signals around the TX scheduler.
interface fir_tx_scheduler_if #(
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned DEPTH     = 8
) ();

  logic                     fir_out_valid;
  logic [OUT_WIDTH-1:0]     fir_out;
  logic                     tx_busy;
  logic                     tx_start;
  logic [7:0]               tx_data;
  logic                     frame_done;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_full;
  logic                     overflow;
  logic                     clr_ovf;

  // master is the scheduler itself
  modport master (
    input  fir_out_valid, fir_out, tx_busy, clr_ovf,
    output tx_start, tx_data, frame_done, fifo_count, fifo_full, overflow
  );

  modport slave (
    output fir_out_valid, fir_out, tx_busy, clr_ovf,
    input  tx_start, tx_data, frame_done, fifo_count, fifo_full, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wr_q] = wdata_i;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fir_tx_scheduler.sv
// Buffers FIR samples and sends each one MSB-byte-first over a start/busy UART TX port.
module fir_tx_scheduler
  import fir_uart_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                clk,
  input  logic                rst,
  fir_tx_scheduler_if.master  bus
);

  localparam int unsigned NBYTES = nbytes(OUT_WIDTH);
  localparam int unsigned SW     = NBYTES * BYTE_W;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  tx_sched_state_t state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic            overflow_q, overflow_d;

  logic                        pop;
  logic                        fifo_full, fifo_empty;
  logic [CW-1:0]               fifo_count;
  logic [OUT_WIDTH-1:0]        fifo_rdata;
  logic signed [OUT_WIDTH-1:0] pop_sample;
  logic                        drop;
  logic                        tx_start, frame_done;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.fir_out_valid),
    .pop_i   (pop),
    .wdata_i (bus.fir_out),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pop_sample = fifo_rdata;
  assign drop       = bus.fir_out_valid && fifo_full && !pop;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          // Sized cast of a signed operand sign-extends to the full byte multiple
          shreg_d = SW'(pop_sample);
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_start = 1'b1;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q != LastIdx) begin
            shreg_d = shreg_q << BYTE_W;
            idx_d   = idx_q + IdxW'(1);
            state_d = SEND;
          end else begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (bus.clr_ovf) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      overflow_q <= overflow_d;
    end
  end

  // tx_start is decoded from state so an asynchronous reset drops it at once
  assign bus.tx_start   = tx_start;
  assign bus.tx_data    = shreg_q[SW-1 -: BYTE_W];
  assign bus.frame_done = frame_done;
  assign bus.fifo_count = fifo_count;
  assign bus.fifo_full  = fifo_full;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_fir_tx_scheduler.sv
// Directed bench: 16-bit/depth-4 and 20-bit/depth-8 schedulers driven by a simple UART model.
module tb_fir_tx_scheduler;

  logic clk;
  logic rst;

  fir_tx_scheduler_if #(.OUT_WIDTH(16), .DEPTH(4)) bus16 ();
  fir_tx_scheduler_if #(.OUT_WIDTH(20), .DEPTH(8)) bus20 ();

  fir_tx_scheduler #(.OUT_WIDTH(16), .DEPTH(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  fir_tx_scheduler #(.OUT_WIDTH(20), .DEPTH(8)) u_dut20 (
    .clk (clk),
    .rst (rst),
    .bus (bus20)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic auto16, auto20, busy_man16, busy_man20;
  logic busy_auto16, busy_auto20;

  assign bus16.tx_busy = auto16 ? busy_auto16 : busy_man16;
  assign bus20.tx_busy = auto20 ? busy_auto20 : busy_man20;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // UART model: busy rises the cycle after tx_start and stays high for 10 cycles
  initial begin
    int  cnt16 = 0, cnt20 = 0;
    bit  pend16 = 0, pend20 = 0;
    busy_auto16 = 1'b0;
    busy_auto20 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto16 || rst) begin
        busy_auto16 = 1'b0; pend16 = 0; cnt16 = 0;
      end else begin
        if (pend16) begin
          busy_auto16 = 1'b1; cnt16 = 10; pend16 = 0;
        end else if (cnt16 > 0) begin
          cnt16--;
          if (cnt16 == 0) busy_auto16 = 1'b0;
        end
        if (bus16.tx_start) pend16 = 1;
      end
      if (!auto20 || rst) begin
        busy_auto20 = 1'b0; pend20 = 0; cnt20 = 0;
      end else begin
        if (pend20) begin
          busy_auto20 = 1'b1; cnt20 = 10; pend20 = 0;
        end else if (cnt20 > 0) begin
          cnt20--;
          if (cnt20 == 0) busy_auto20 = 1'b0;
        end
        if (bus20.tx_start) pend20 = 1;
      end
    end
  end

  initial begin
    logic [15:0] s [7];
    logic [7:0]  bytes [4];
    int          nst, ndone;

    s[0] = 16'h1101; s[1] = 16'h2202; s[2] = 16'h3303; s[3] = 16'h4404;
    s[4] = 16'h5505; s[5] = 16'h6606; s[6] = 16'h7707;

    rst = 1'b1;
    auto16 = 1'b0; auto20 = 1'b0; busy_man16 = 1'b0; busy_man20 = 1'b0;
    bus16.fir_out_valid = 1'b0; bus16.fir_out = '0; bus16.clr_ovf = 1'b0;
    bus20.fir_out_valid = 1'b0; bus20.fir_out = '0; bus20.clr_ovf = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_tx_start", 32'(bus16.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus16.tx_data), 32'd0);
    check("rst_frame_done", 32'(bus16.frame_done), 32'd0);
    check("rst_count", 32'(bus16.fifo_count), 32'd0);
    check("rst_full", 32'(bus16.fifo_full), 32'd0);
    check("rst_overflow", 32'(bus16.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: 16-bit sample, two bytes MSB first, tx_start 2 cycles after valid
    auto16 = 1'b1;
    bus16.fir_out_valid = 1'b1; bus16.fir_out = 16'hA55A;
    @(negedge clk);
    bus16.fir_out_valid = 1'b0;
    check("t1_count_after_push", 32'(bus16.fifo_count), 32'd1);
    check("t1_no_early_start", 32'(bus16.tx_start), 32'd0);
    @(negedge clk);
    check("t1_start_latency", 32'(bus16.tx_start), 32'd1);
    check("t1_byte0", 32'(bus16.tx_data), 32'hA5);
    nst = 1; ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus16.tx_start) begin
        if (nst < 4) bytes[nst] = bus16.tx_data;
        nst++;
      end
      if (bus16.frame_done) ndone++;
    end
    check("t1_start_count", 32'(nst), 32'd2);
    check("t1_byte1", 32'(bytes[1]), 32'h5A);
    check("t1_frame_done_count", 32'(ndone), 32'd1);
    check("t1_count_final", 32'(bus16.fifo_count), 32'd0);
    auto16 = 1'b0;

    // 2: 20-bit negative sample, sign-extended to three bytes
    auto20 = 1'b1;
    bus20.fir_out_valid = 1'b1; bus20.fir_out = 20'h81234;
    @(negedge clk);
    bus20.fir_out_valid = 1'b0;
    nst = 0; ndone = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus20.tx_start) begin
        if (nst < 4) bytes[nst] = bus20.tx_data;
        nst++;
      end
      if (bus20.frame_done) ndone++;
    end
    check("t2_start_count", 32'(nst), 32'd3);
    check("t2_byte0_signext", 32'(bytes[0]), 32'hF8);
    check("t2_byte1", 32'(bytes[1]), 32'h12);
    check("t2_byte2", 32'(bytes[2]), 32'h34);
    check("t2_frame_done_count", 32'(ndone), 32'd1);
    auto20 = 1'b0;
    @(negedge clk);

    // 3: busy held high, six back-to-back pushes into a depth-4 FIFO
    busy_man16 = 1'b1;
    bus16.fir_out_valid = 1'b1; bus16.fir_out = s[0];
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check("t3_full_before_drop", 32'(bus16.fifo_full), 32'd1);
        check("t3_no_ovf_before_drop", 32'(bus16.overflow), 32'd0);
      end
      bus16.fir_out = s[i];
    end
    @(negedge clk);
    bus16.fir_out_valid = 1'b0;
    check("t3_count", 32'(bus16.fifo_count), 32'd4);
    check("t3_full", 32'(bus16.fifo_full), 32'd1);
    check("t3_overflow", 32'(bus16.overflow), 32'd1);
    check("t3_first_byte", 32'(bus16.tx_data), 32'h11);
    bus16.clr_ovf = 1'b1;
    @(negedge clk);
    bus16.clr_ovf = 1'b0;
    check("t3_clr_ovf", 32'(bus16.overflow), 32'd0);
    check("t3_count_held", 32'(bus16.fifo_count), 32'd4);
    busy_man16 = 1'b0;

    // 4: finish first frame, then push and pop together while full
    @(negedge clk);
    check("t4_second_start", 32'(bus16.tx_start), 32'd1);
    check("t4_second_byte", 32'(bus16.tx_data), 32'h01);
    busy_man16 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    busy_man16 = 1'b0;
    #1;
    check("t4_frame_done", 32'(bus16.frame_done), 32'd1);
    @(negedge clk);
    check("t4_idle_no_start", 32'(bus16.tx_start), 32'd0);
    bus16.fir_out_valid = 1'b1; bus16.fir_out = s[6];
    @(negedge clk);
    bus16.fir_out_valid = 1'b0;
    check("t4_count_push_pop", 32'(bus16.fifo_count), 32'd4);
    check("t4_full_push_pop", 32'(bus16.fifo_full), 32'd1);
    check("t4_no_overflow", 32'(bus16.overflow), 32'd0);
    check("t4_next_start", 32'(bus16.tx_start), 32'd1);
    check("t4_next_byte", 32'(bus16.tx_data), 32'h22);

    // 5: late ack, FSM waits without re-pulsing and tx_data holds
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_repulse", 32'(bus16.tx_start), 32'd0);
      check("t5_data_stable", 32'(bus16.tx_data), 32'h22);
    end
    busy_man16 = 1'b1;
    @(negedge clk);
    busy_man16 = 1'b0;
    @(negedge clk);
    check("t6_second_byte_start", 32'(bus16.tx_start), 32'd1);
    check("t6_second_byte", 32'(bus16.tx_data), 32'h02);

    // 6: asynchronous reset mid-frame with samples still queued
    rst = 1'b1;
    #1;
    check("t6_start_drop", 32'(bus16.tx_start), 32'd0);
    check("t6_count_clear", 32'(bus16.fifo_count), 32'd0);
    check("t6_full_clear", 32'(bus16.fifo_full), 32'd0);
    check("t6_data_clear", 32'(bus16.tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nst = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus16.tx_start) nst++;
    end
    check("t6_no_tx_after_rst", 32'(nst), 32'd0);
    bus16.fir_out_valid = 1'b1; bus16.fir_out = 16'h3344;
    @(negedge clk);
    bus16.fir_out_valid = 1'b0;
    @(negedge clk);
    check("t6_restart_start", 32'(bus16.tx_start), 32'd1);
    check("t6_restart_byte", 32'(bus16.tx_data), 32'h33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
